// File: rtl/ssd1306_spi_rx.sv
// SSD1306-style 4-wire SPI receiver, oversampled in the pixel clock domain.
// Decodes framebuffer addressing and display control commands. Each data byte
// produces one framebuffer write.
// Optional: define SSD1306_SEGREMAP_EN to enable the 0xA0/0xA1 column remap.
module ssd1306_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 8,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              CLK25MHz,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  input  logic              dc,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              invert,
  output logic              display_on
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned PW = $clog2(PAGES);

  typedef enum logic [2:0] {StIdle, StColS, StColE, StPgS, StPgE, StMode, StSkip} parser_e;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, dc_sync;
  logic                   sclk_prev;
  logic                   sclk_s, mosi_s, cs_s, dc_s, sclk_rise;

  logic [6:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  parser_e       state;
  logic [1:0]    mode;
  logic [CW-1:0] col, col_start, col_end, col_next, col_adv, col_eff;
  logic [PW-1:0] page, page_start, page_end, page_next, page_adv;
  logic          col_wrap, page_wrap;
  logic [ADDR_W-1:0] addr_now;
`ifdef SSD1306_SEGREMAP_EN
  logic          segremap;
`endif

  // Input synchronisers and sclk edge history; cs_n idles deasserted.
  always_ff @(posedge CLK25MHz or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign rx_byte   = {shreg, mosi_s};

  // Pointer sequencing: end register reloads start, otherwise modulo increment.
  always_comb begin
    col_wrap  = (col == col_end) || (col == CW'(COLS - 1));
    page_wrap = (page == page_end) || (page == PW'(PAGES - 1));
    if (col == col_end)              col_next = col_start;
    else if (col == CW'(COLS - 1))   col_next = '0;
    else                             col_next = col + 1'b1;
    if (page == page_end)            page_next = page_start;
    else if (page == PW'(PAGES - 1)) page_next = '0;
    else                             page_next = page + 1'b1;
    col_adv  = col;
    page_adv = page;
    case (mode)
      2'd0: begin
        col_adv = col_next;
        if (col_wrap) page_adv = page_next;
      end
      2'd1: begin
        page_adv = page_next;
        if (page_wrap) col_adv = col_next;
      end
      default: col_adv = col_next;
    endcase
`ifdef SSD1306_SEGREMAP_EN
    col_eff = segremap ? (CW'(COLS - 1) - col) : col;
`else
    col_eff = col;
`endif
    addr_now = ADDR_W'(page) * ADDR_W'(COLS) + ADDR_W'(col_eff);
  end

  // Byte assembly, data writes and command parser FSM.
  always_ff @(posedge CLK25MHz or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      state      <= StIdle;
      mode       <= 2'd2;
      col        <= '0;
      page       <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      invert     <= 1'b0;
      display_on <= 1'b0;
`ifdef SSD1306_SEGREMAP_EN
      segremap   <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg <= rx_byte[6:0];
        if (bit_cnt != 3'd7) begin
          bit_cnt <= bit_cnt + 3'd1;
        end else begin
          bit_cnt <= '0;
          if (dc_s) begin
            // Write uses the pre-advance pointer; parser state is untouched.
            wr_en   <= 1'b1;
            wr_data <= rx_byte;
            wr_addr <= addr_now;
            col     <= col_adv;
            page    <= page_adv;
          end else begin
            case (state)
              StIdle: begin
                if (rx_byte == 8'h21)      state <= StColS;
                else if (rx_byte == 8'h22) state <= StPgS;
                else if (rx_byte == 8'h20) state <= StMode;
                else if (rx_byte inside {8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA,
                                         8'hDB, 8'h8D})
                  state <= StSkip;
                else if (rx_byte[7:4] == 4'h0) col <= {col[CW-1:4], rx_byte[3:0]};
                else if (rx_byte[7:3] == 5'b00010) col <= {rx_byte[CW-5:0], col[3:0]};
                else if (rx_byte[7:3] == 5'b10110) page <= rx_byte[PW-1:0];
                else if (rx_byte[7:1] == 7'b1010011) invert <= rx_byte[0];
                else if (rx_byte[7:1] == 7'b1010111) display_on <= rx_byte[0];
`ifdef SSD1306_SEGREMAP_EN
                else if (rx_byte[7:1] == 7'b1010000) segremap <= rx_byte[0];
`endif
              end
              StColS: begin
                col_start <= rx_byte[CW-1:0];
                col       <= rx_byte[CW-1:0];
                state     <= StColE;
              end
              StColE: begin
                col_end <= rx_byte[CW-1:0];
                state   <= StIdle;
              end
              StPgS: begin
                page_start <= rx_byte[PW-1:0];
                page       <= rx_byte[PW-1:0];
                state      <= StPgE;
              end
              StPgE: begin
                page_end <= rx_byte[PW-1:0];
                state    <= StIdle;
              end
              StMode: begin
                mode  <= (rx_byte[1:0] == 2'd3) ? 2'd2 : rx_byte[1:0];
                state <= StIdle;
              end
              default: state <= StIdle;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Scoreboard bench for ssd1306_spi_rx: expected writes are queued as data bytes
// are sent and compared when wr_en pulses.
module tb_ssd1306_spi_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, dc = 1'b0;
  logic       wr_en, invert, display_on;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [9:0]  exp_addr_q[$];
  logic [7:0]  exp_data_q[$];

  always #20 clk = ~clk;

  ssd1306_spi_rx dut (
    .CLK25MHz  (clk),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .dc        (dc),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .invert    (invert),
    .display_on(display_on)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_wr", 32'(wr_addr), 32'h3ff);
      end else begin
        check("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
        check("wr_data", 32'(wr_data), 32'(exp_data_q.pop_front()));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    sclk = 1'b0;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic is_data, input logic [7:0] b);
    dc = is_data;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_byte(1'b0, b);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [9:0] exp_addr);
    exp_addr_q.push_back(exp_addr);
    exp_data_q.push_back(b);
    spi_byte(1'b1, b);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_addr_q.size() != 0; i++) wait_clk(1);
    wait_clk(8);
    check(tag, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    logic [9:0] seg_addr;
    do_reset();
    @(negedge clk);
    check("reset_outputs", {19'd0, wr_en, wr_addr, wr_data, invert, display_on}, 32'd0);
    cs_n = 1'b0;
    wait_clk(4);

    // Horizontal mode, two sequential writes.
    send_cmd(8'h20); send_cmd(8'h00);
    send_data(8'h11, 10'd0);
    send_data(8'h22, 10'd1);
    drain("drain_horiz");

    // Window at the last column pair of the last page; both pointers wrap.
    send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
    send_cmd(8'h22); send_cmd(8'h07); send_cmd(8'h07);
    send_data(8'h01, 10'd1022);
    send_data(8'h02, 10'd1023);
    send_data(8'h03, 10'd1022);
    drain("drain_window");

    // Page mode addressing via nibble and page commands.
    do_reset();
    send_cmd(8'hB3); send_cmd(8'h05); send_cmd(8'h12);
    send_data(8'hAA, 10'd421);
    send_data(8'h55, 10'd422);
    // Vertical mode: page advances, column held.
    send_cmd(8'h20); send_cmd(8'h01);
    send_data(8'h0F, 10'd423);
    send_data(8'hF0, 10'd551);
    // Mode 3 behaves as page mode.
    send_cmd(8'h20); send_cmd(8'h03);
    send_data(8'h77, 10'd679);
    send_data(8'h88, 10'd680);
    drain("drain_modes");

    // Display flags and skipped contrast argument.
    send_cmd(8'hA7); send_cmd(8'hAF);
    wait_clk(8);
    check("invert_set", 32'(invert), 32'd1);
    check("display_on_set", 32'(display_on), 32'd1);
    send_cmd(8'h81); send_cmd(8'hA6);
    wait_clk(8);
    check("invert_after_skip", 32'(invert), 32'd1);
    send_cmd(8'hA6); send_cmd(8'hAE);
    wait_clk(8);
    check("invert_clr", 32'(invert), 32'd0);
    check("display_on_clr", 32'(display_on), 32'd0);

    // Partial byte discarded by cs_n deassertion.
    do_reset();
    dc = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_n = 1'b1;
    wait_clk(8);
    cs_n = 1'b0;
    wait_clk(8);
    send_data(8'h3C, 10'd0);
    drain("drain_cs_abort");

    // Asynchronous reset mid-byte, then a fresh byte.
    send_cmd(8'hA7); send_cmd(8'hAF);
    send_data(8'hC3, 10'd1);
    drain("drain_pre_reset");
    check("pre_reset_invert", 32'(invert), 32'd1);
    dc = 1'b1;
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    @(posedge clk);
    #5 reset_n = 1'b0;
    #1 check("async_reset", {19'd0, wr_en, wr_addr, wr_data, invert, display_on}, 32'd0);
    wait_clk(2);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clk(4);
    send_data(8'h5A, 10'd0);
    drain("drain_post_reset");

    // Column remap (optional build).
    do_reset();
`ifdef SSD1306_SEGREMAP_EN
    seg_addr = 10'd127;
`else
    seg_addr = 10'd0;
`endif
    send_cmd(8'hA1); send_cmd(8'h20); send_cmd(8'h00);
    send_data(8'h99, seg_addr);
    drain("drain_segremap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
